song_sequencer: RTL and testbench

// - Plays songs for the synth voice path by reading one event per note step from a song ROM through a req/ack handshake.
// - Drives the four tone codes (tone0..tone3) into tone_gen at a programmable tempo and holds each event for its encoded duration.
// - Supports play/pause and signals end-of-song. Replaces the free-running note-clock song FSM and runs in the slow (chip) clock domain.

---
 rtl/synth_pkg.sv | 35 +++
 rtl/tempo_tick.sv | 44 ++++
 rtl/song_sequencer.sv | 176 +++++++++++++++++
 tb/tb_song_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: tone code widths, song event
// layout ({dur[3:0], tone3, tone2, tone1, tone0}) and sequencer state encoding.
package synth_pkg;

   localparam int TONE_W    = 4;
   localparam int NUM_TONES = 4;
   localparam int DUR_W     = 4;
   localparam int DUR_LSB   = 16;
   localparam int EVENT_W   = 20;

   localparam logic [TONE_W-1:0] TONE_REST = 4'h0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // Bit offset of tone n inside a song event.
   function automatic int tone_lsb(input int n);
      tone_lsb = TONE_W * n;
   endfunction

   // Extract tone n from a song event.
   function automatic logic [TONE_W-1:0] event_tone(input logic [EVENT_W-1:0] ev, input int n);
      event_tone = ev[tone_lsb(n) +: TONE_W];
   endfunction

   // Extract the duration field (in ticks minus one) from a song event.
   function automatic logic [DUR_W-1:0] event_dur(input logic [EVENT_W-1:0] ev);
      event_dur = ev[DUR_LSB +: DUR_W];
   endfunction

endpackage

// File: rtl/tempo_tick.sv
// Tempo divider: emits a registered one-cycle tick every DIV cycles.
// Asserting clr restarts the period so the first tick lands DIV cycles later.
module tempo_tick #(
   parameter int DIV = 768000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             tick_r;

   // Next counter value: restart on clr, wrap after DIV-1.
   always_comb begin
      cnt_next_s = {CNT_W{1'b0}};
      if (clr) begin
         cnt_next_s = {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
         cnt_next_s = {CNT_W{1'b0}};
      end else begin
         cnt_next_s = cnt_r + CNT_W'(1);
      end
   end

   // Counter and tick registers; tick is high in the cycle the count sits at DIV-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r  <= {CNT_W{1'b0}};
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_next_s;
         tick_r <= (cnt_next_s == CNT_MAX);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: fetches one event per note step from the song ROM over a
// req/ack handshake, drives four tone codes and holds each event for
// (dur+1) tempo ticks. Play/pause via the play level.
// Build option: define SONG_SEQUENCER_LOOP_EN to wrap back to event 0 after
// the last event instead of stopping in DONE (done is then tied low).
module song_sequencer
   import synth_pkg::*;
#(
   parameter int CLK_HZ   = 12_288_000,
   parameter int TICK_HZ  = 16,
   parameter int ADDR_W   = 8,
   parameter int SONG_LEN = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                play,
   output logic                rom_req,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic                rom_ack,
   input  logic [EVENT_W-1:0]  rom_data,
   output logic [TONE_W-1:0]   tone0,
   output logic [TONE_W-1:0]   tone1,
   output logic [TONE_W-1:0]   tone2,
   output logic [TONE_W-1:0]   tone3,
   output logic [ADDR_W-1:0]   note_index,
   output logic                busy,
   output logic                done
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

   seq_state_t                          state_r;
   seq_state_t                          state_next_s;
   logic [NUM_TONES-1:0][TONE_W-1:0]    tones_r;
   logic [NUM_TONES-1:0][TONE_W-1:0]    tones_next_s;
   logic [ADDR_W-1:0]                   idx_r;
   logic [ADDR_W-1:0]                   idx_next_s;
   logic [DUR_W-1:0]                    dur_cnt_r;
   logic [DUR_W-1:0]                    dur_cnt_next_s;
   logic                                clr_s;
   logic                                tick_s;
   logic                                rom_req_r;
   logic                                busy_r;

   tempo_tick #(
      .DIV (DIV)
   ) u_tempo_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .tick  (tick_s)
   );

   // Next-state, next-tone, note index and duration bookkeeping.
   always_comb begin
      state_next_s   = state_r;
      tones_next_s   = tones_r;
      idx_next_s     = idx_r;
      dur_cnt_next_s = dur_cnt_r;
      clr_s          = 1'b0;
      case (state_r)
         IDLE: begin
            tones_next_s = {NUM_TONES{TONE_REST}};
            if (play) begin
               state_next_s = FETCH;
            end else begin
               state_next_s = IDLE;
            end
         end
         FETCH: begin
            // The handshake always completes; play only decides whether the data is used.
            if (rom_ack) begin
               if (play) begin
                  state_next_s   = HOLD;
                  dur_cnt_next_s = event_dur(rom_data);
                  clr_s          = 1'b1;
                  for (int n = 0; n < NUM_TONES; n++) begin
                     tones_next_s[n] = event_tone(rom_data, n);
                  end
               end else begin
                  state_next_s = IDLE;
                  tones_next_s = {NUM_TONES{TONE_REST}};
               end
            end else begin
               state_next_s = FETCH;
            end
         end
         HOLD: begin
            // Pause has priority over a coincident tick wrap.
            if (!play) begin
               state_next_s = IDLE;
               tones_next_s = {NUM_TONES{TONE_REST}};
            end else if (tick_s) begin
               if (dur_cnt_r == {DUR_W{1'b0}}) begin
                  if (idx_r != LAST_IDX) begin
                     idx_next_s   = idx_r + ADDR_W'(1);
                     state_next_s = FETCH;
                  end else begin
`ifdef SONG_SEQUENCER_LOOP_EN
                     idx_next_s   = {ADDR_W{1'b0}};
                     state_next_s = FETCH;
`else
                     state_next_s = DONE;
                     tones_next_s = {NUM_TONES{TONE_REST}};
`endif
                  end
               end else begin
                  dur_cnt_next_s = dur_cnt_r - DUR_W'(1);
               end
            end else begin
               state_next_s = HOLD;
            end
         end
         DONE: begin
            tones_next_s = {NUM_TONES{TONE_REST}};
            if (!play) begin
               state_next_s = IDLE;
               idx_next_s   = {ADDR_W{1'b0}};
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
            tones_next_s = {NUM_TONES{TONE_REST}};
         end
      endcase
   end

   // State, datapath and registered handshake/status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         tones_r   <= {NUM_TONES{TONE_REST}};
         idx_r     <= {ADDR_W{1'b0}};
         dur_cnt_r <= {DUR_W{1'b0}};
         rom_req_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         tones_r   <= tones_next_s;
         idx_r     <= idx_next_s;
         dur_cnt_r <= dur_cnt_next_s;
         rom_req_r <= (state_next_s == FETCH);
         busy_r    <= (state_next_s == FETCH) || (state_next_s == HOLD);
      end
   end

`ifdef SONG_SEQUENCER_LOOP_EN
   assign done = 1'b0;
`else
   logic done_r;

   // End-of-song flag, registered alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_r <= 1'b0;
      end else begin
         done_r <= (state_next_s == DONE);
      end
   end

   assign done = done_r;
`endif

   assign rom_req    = rom_req_r;
   assign rom_addr   = idx_r;
   assign note_index = idx_r;
   assign busy       = busy_r;
   assign tone0      = tones_r[0];
   assign tone1      = tones_r[1];
   assign tone2      = tones_r[2];
   assign tone3      = tones_r[3];

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: CLK_HZ=100, TICK_HZ=10 (DIV=10), SONG_LEN=4.
// The ROM model acks 2 cycles after rom_req rises.
module tb_song_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        play = 1'b0;
   logic        rom_req;
   logic [7:0]  rom_addr;
   logic        rom_ack = 1'b0;
   logic [19:0] rom_data = 20'h0_0000;
   logic [3:0]  tone0, tone1, tone2, tone3;
   logic [7:0]  note_index;
   logic        busy;
   logic        done;
   logic [15:0] tones_all;

   typedef struct {
      logic [19:0] data;
      logic [15:0] tones;
      int          hold;
   } vec_t;

   vec_t        vecs [4];
   logic [15:0] prev_tones = 16'h0000;
   int          tests = 0;
   int          fails = 0;
   int          rom_age = 0;

   assign tones_all = {tone3, tone2, tone1, tone0};

   always #5 clk = ~clk;

   song_sequencer #(
      .CLK_HZ   (100),
      .TICK_HZ  (10),
      .ADDR_W   (8),
      .SONG_LEN (4)
   ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .play       (play),
      .rom_req    (rom_req),
      .rom_addr   (rom_addr),
      .rom_ack    (rom_ack),
      .rom_data   (rom_data),
      .tone0      (tone0),
      .tone1      (tone1),
      .tone2      (tone2),
      .tone3      (tone3),
      .note_index (note_index),
      .busy       (busy),
      .done       (done)
   );

   // ROM model: ack pulse one clock, raised on the second negedge with rom_req high.
   always @(negedge clk) begin
      if (rom_ack) begin
         rom_ack = 1'b0;
         rom_age = 0;
      end else if (rom_req) begin
         rom_age = rom_age + 1;
         if (rom_age == 2) begin
            rom_ack  = 1'b1;
            rom_data = vecs[int'(rom_addr[1:0])].data;
         end
      end else begin
         rom_age = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_req();
      int k;
      k = 0;
      while (!rom_req && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("fetch_req", {31'd0, rom_req}, 32'd1);
   endtask

   task automatic wait_fetch_end();
      int k;
      k = 0;
      while (rom_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("fetch_end", {31'd0, rom_req}, 32'd0);
   endtask

   // Full fetch + hold of event i with uninterrupted play.
   task automatic run_event(input int i);
      int fc, glitch, hold, bad;
      wait_req();
      check("fetch_addr", {24'd0, rom_addr}, i);
      fc = 0;
      glitch = 0;
      while (rom_req && fc < 50) begin
         if (tones_all !== prev_tones) glitch++;
         fc++;
         @(negedge clk);
      end
      check("fetch_len", fc, 32'd2);
      check("fetch_glitch", glitch, 32'd0);
      hold = 0;
      bad = 0;
      while (busy && !rom_req && hold < 500) begin
         if (tones_all !== vecs[i].tones) bad++;
         hold++;
         @(negedge clk);
      end
      check("hold_len", hold, vecs[i].hold);
      check("hold_tones", bad, 32'd0);
      prev_tones = vecs[i].tones;
   endtask

   // Behaviour after the last event, ending in IDLE with note_index 0.
   task automatic finish_song();
`ifdef SONG_SEQUENCER_LOOP_EN
      check("loop_req", {31'd0, rom_req}, 32'd1);
      check("loop_addr", {24'd0, rom_addr}, 32'd0);
      check("loop_done", {31'd0, done}, 32'd0);
      play = 1'b0;
      wait_fetch_end();
      check("loop_idle_busy", {31'd0, busy}, 32'd0);
      check("loop_idle_tones", {16'd0, tones_all}, 32'd0);
      check("loop_idle_idx", {24'd0, note_index}, 32'd0);
`else
      check("done_set", {31'd0, done}, 32'd1);
      check("done_tones", {16'd0, tones_all}, 32'd0);
      check("done_busy", {31'd0, busy}, 32'd0);
      repeat (5) @(negedge clk);
      check("done_stay", {31'd0, done}, 32'd1);
      check("done_no_req", {31'd0, rom_req}, 32'd0);
      play = 1'b0;
      @(negedge clk);
      check("done_clear", {31'd0, done}, 32'd0);
      check("done_idx0", {24'd0, note_index}, 32'd0);
`endif
      prev_tones = 16'h0000;
   endtask

   initial begin
      int bad;
      vecs[0] = '{data: 20'h1_4321, tones: 16'h4321, hold: 20};
      vecs[1] = '{data: 20'h0_8765, tones: 16'h8765, hold: 10};
      vecs[2] = '{data: 20'h2_CBA9, tones: 16'hCBA9, hold: 30};
      vecs[3] = '{data: 20'h0_0F0E, tones: 16'h0F0E, hold: 10};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tones", {16'd0, tones_all}, 32'd0);
      check("rst_idx", {24'd0, note_index}, 32'd0);
      check("rst_req", {31'd0, rom_req}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Pass 1: whole song
      play = 1'b1;
      @(negedge clk);
      check("start_req", {31'd0, rom_req}, 32'd1);
      check("start_addr", {24'd0, rom_addr}, 32'd0);
      for (int i = 0; i < 4; i++) run_event(i);
      finish_song();

      // play dropped during FETCH: ack consumed, tones not updated
      play = 1'b1;
      @(negedge clk);
      check("drop_req", {31'd0, rom_req}, 32'd1);
      play = 1'b0;
      wait_fetch_end();
      check("drop_busy", {31'd0, busy}, 32'd0);
      check("drop_tones", {16'd0, tones_all}, 32'd0);
      check("drop_idx", {24'd0, note_index}, 32'd0);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (rom_req !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("drop_stay_idle", bad, 32'd0);

      // Pause coincident with the final tick wrap of event 0: pause wins
      play = 1'b1;
      wait_req();
      wait_fetch_end();
      repeat (19) @(negedge clk);
      check("wrap_still_hold", {31'd0, busy}, 32'd1);
      check("wrap_tones", {16'd0, tones_all}, 32'h4321);
      play = 1'b0;
      @(negedge clk);
      check("wrap_pause_busy", {31'd0, busy}, 32'd0);
      check("wrap_pause_idx", {24'd0, note_index}, 32'd0);
      check("wrap_pause_req", {31'd0, rom_req}, 32'd0);
      @(negedge clk);
      prev_tones = 16'h0000;
      play = 1'b1;
      run_event(0);
      run_event(1);

      // Pause mid-HOLD of event 2, then resume
      wait_req();
      check("p2_addr", {24'd0, rom_addr}, 32'd2);
      wait_fetch_end();
      repeat (7) @(negedge clk);
      play = 1'b0;
      @(negedge clk);
      check("pause_tones", {16'd0, tones_all}, 32'd0);
      check("pause_idx", {24'd0, note_index}, 32'd2);
      check("pause_busy", {31'd0, busy}, 32'd0);
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (rom_req !== 1'b0 || note_index !== 8'd2) bad++;
      end
      check("pause_stay", bad, 32'd0);
      prev_tones = 16'h0000;
      play = 1'b1;
      run_event(2);
      run_event(3);
      finish_song();

      // Async reset during a fetch with non-zero tones on the outputs
      play = 1'b1;
      run_event(0);
      wait_req();
      check("rst2_addr", {24'd0, rom_addr}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_req", {31'd0, rom_req}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_tones", {16'd0, tones_all}, 32'd0);
      check("arst_idx", {24'd0, note_index}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_req", {31'd0, rom_req}, 32'd1);
      check("rel_addr", {24'd0, rom_addr}, 32'd0);
      play = 1'b0;
      wait_fetch_end();
      check("rel_idle", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
